// File: rtl/mio_pkg.sv
// Shared MIO helpers: width legality, clog2 and beat/mask arithmetic for the
// transmit packetizer.
package mio_pkg;

  function automatic bit mio_iow_ok(input int iow);
    return (iow == 8) || (iow == 16) || (iow == 32) || (iow == 64);
  endfunction

  function automatic int mio_clog2(input int v);
    int r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // Beats per packet
  function automatic int mio_nb(input int pw, input int iow);
    return (pw + iow - 1) / iow;
  endfunction

  // Bytes carried by the last beat (1..iow/8)
  function automatic int mio_lb(input int pw, input int iow);
    return pw / 8 - (mio_nb(pw, iow) - 1) * (iow / 8);
  endfunction

  function automatic logic [7:0] mio_full_mask(input int iow);
    return 8'((1 << (iow / 8)) - 1);
  endfunction

  function automatic logic [7:0] mio_last_mask(input int pw, input int iow);
    return 8'((1 << mio_lb(pw, iow)) - 1);
  endfunction

endpackage

// File: rtl/mtx_skid.sv
// One-entry input skid buffer; parks a packet while the packer's holding
// register is still draining.
module mtx_skid #(
  parameter int DW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic          o_full,
  output logic [DW-1:0] o_data
);

  logic          r_full;
  logic [DW-1:0] r_data;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (i_push) begin
      r_full <= 1'b1;
      r_data <= i_data;
    end else if (i_pop) begin
      r_full <= 1'b0;
    end
  end

  assign o_full = r_full;
  assign o_data = r_data;

endmodule

// File: rtl/mtx_pack.sv
// MIO transmit packetizer: splits PW-bit packets into IOW-wide beats with a
// per-byte valid mask. Optional input skid buffer under MTX_PACK_SKIDBUF_EN.
module mtx_pack
  import mio_pkg::*;
#(
  parameter int PW  = 104,
  parameter int IOW = 64
) (
  input  logic           io_clk,
  input  logic           reset,
  input  logic           access_in,
  input  logic [PW-1:0]  packet_in,
  output logic           wait_out,
  output logic [7:0]     io_valid,
  output logic [IOW-1:0] io_packet,
  input  logic           io_wait
);

  localparam int NB   = mio_nb(PW, IOW);
  localparam int CW   = (mio_clog2(NB) < 1) ? 1 : mio_clog2(NB);
  localparam int PADW = NB * IOW;
  localparam logic [CW-1:0] LAST_CNT  = CW'(NB - 1);
  localparam logic [7:0]    FULL_MASK = mio_full_mask(IOW);
  localparam logic [7:0]    LAST_MASK = mio_last_mask(PW, IOW);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  if (!mio_iow_ok(IOW) || (PW % 8) != 0 || PW < IOW) begin : g_bad_cfg
    $error("mtx_pack: illegal PW/IOW combination");
  end

  logic [0:0]     r_state;
  logic [CW-1:0]  r_cnt;
  logic [PW-1:0]  r_hold;
  logic [7:0]     r_valid;
  logic [IOW-1:0] r_pkt;

  logic           w_last, w_cons, w_free, w_wait, w_load;
  logic [PW-1:0]  w_load_data;
  logic [0:0]     w_nxt_state;
  logic [CW-1:0]  w_nxt_cnt;
  logic [PW-1:0]  w_nxt_hold;
  logic [PADW-1:0] w_pad;
  logic [IOW-1:0] w_beat;

  assign w_last = (r_cnt == LAST_CNT);
  assign w_cons = (r_state == S_SEND) & ~io_wait;
  // Holding register can take a new packet this edge
  assign w_free = (r_state == S_IDLE) | (w_cons & w_last);

`ifdef MTX_PACK_SKIDBUF_EN
  logic          w_acc, w_push, w_pop, w_skid_full;
  logic [PW-1:0] w_skid_data;

  assign w_wait      = w_skid_full;
  assign w_acc       = access_in & ~w_skid_full;
  assign w_push      = w_acc & ~w_free;
  assign w_pop       = w_free & w_skid_full;
  assign w_load      = w_pop | (w_acc & w_free);
  assign w_load_data = w_skid_full ? w_skid_data : packet_in;

  mtx_skid #(.DW(PW)) u_skid (
    .i_clk  (io_clk),
    .i_rst  (reset),
    .i_push (w_push),
    .i_data (packet_in),
    .i_pop  (w_pop),
    .o_full (w_skid_full),
    .o_data (w_skid_data)
  );
`else
  // Combinational from io_wait: last-beat consume frees the holder this cycle
  assign w_wait      = ~w_free;
  assign w_load      = access_in & w_free;
  assign w_load_data = packet_in;
`endif

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_hold  = r_hold;
    if (w_load) begin
      w_nxt_state = S_SEND;
      w_nxt_cnt   = '0;
      w_nxt_hold  = w_load_data;
    end else if (w_cons) begin
      if (w_last) begin
        w_nxt_state = S_IDLE;
        w_nxt_cnt   = '0;
      end else begin
        w_nxt_cnt = r_cnt + CW'(1);
      end
    end
  end

  assign w_pad  = PADW'(w_nxt_hold);
  assign w_beat = w_pad[int'(w_nxt_cnt) * IOW +: IOW];

  always_ff @(posedge io_clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_hold  <= '0;
      r_valid <= '0;
      r_pkt   <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_hold  <= w_nxt_hold;
      if (w_nxt_state == S_SEND) begin
        r_valid <= (w_nxt_cnt == LAST_CNT) ? LAST_MASK : FULL_MASK;
        r_pkt   <= w_beat;
      end else begin
        r_valid <= '0;
        r_pkt   <= '0;
      end
    end
  end

  assign wait_out  = w_wait;
  assign io_valid  = r_valid;
  assign io_packet = r_pkt;

endmodule

// File: tb/tb_mtx_pack.sv
// Directed bench for mtx_pack in three geometries (104/64, 64/64, 40/16)
// with per-instance beat scoreboards.
module tb_mtx_pack;

  logic io_clk = 1'b0;
  logic reset  = 1'b1;
  always #5 io_clk = ~io_clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic         acc0 = 1'b0, iw0 = 1'b0, wt0;
  logic [103:0] pk0  = '0;
  logic [7:0]   v0;
  logic [63:0]  d0;

  logic         acc1 = 1'b0, iw1 = 1'b0, wt1;
  logic [63:0]  pk1  = '0;
  logic [7:0]   v1;
  logic [63:0]  d1;

  logic         acc2 = 1'b0, iw2 = 1'b0, wt2;
  logic [39:0]  pk2  = '0;
  logic [7:0]   v2;
  logic [15:0]  d2;

  logic [71:0] q0[$];
  logic [71:0] q1[$];
  logic [71:0] q2[$];

  mtx_pack #(.PW(104), .IOW(64)) u_d0 (
    .io_clk(io_clk), .reset(reset), .access_in(acc0), .packet_in(pk0),
    .wait_out(wt0), .io_valid(v0), .io_packet(d0), .io_wait(iw0));

  mtx_pack #(.PW(64), .IOW(64)) u_d1 (
    .io_clk(io_clk), .reset(reset), .access_in(acc1), .packet_in(pk1),
    .wait_out(wt1), .io_valid(v1), .io_packet(d1), .io_wait(iw1));

  mtx_pack #(.PW(40), .IOW(16)) u_d2 (
    .io_clk(io_clk), .reset(reset), .access_in(acc2), .packet_in(pk2),
    .wait_out(wt2), .io_valid(v2), .io_packet(d2), .io_wait(iw2));

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push0(input logic [103:0] p);
    q0.push_back({8'hFF, p[63:0]});
    q0.push_back({8'h1F, 24'h0, p[103:64]});
  endtask

  task automatic push1(input logic [63:0] p);
    q1.push_back({8'hFF, p});
  endtask

  task automatic push2(input logic [39:0] p);
    q2.push_back({8'h03, 48'h0, p[15:0]});
    q2.push_back({8'h03, 48'h0, p[31:16]});
    q2.push_back({8'h01, 48'h0, 8'h0, p[39:32]});
  endtask

  function automatic logic [103:0] rnd104();
    return 104'({$urandom(), $urandom(), $urandom(), $urandom()});
  endfunction

  // Offer one packet to d0; returns at posedge+1 after the accepting edge
  task automatic offer0(input logic [103:0] p);
    bit ok = 1'b0;
    acc0 = 1'b1;
    pk0  = p;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge io_clk);
      if (!wt0) begin
        push0(p);
        ok = 1'b1;
      end
      @(posedge io_clk); #1;
    end
    acc0 = 1'b0;
    chk("offer0 accepted", 72'(ok), 72'd1);
  endtask

  // Scoreboard: every consumed beat must match the next expected beat
  always @(negedge io_clk) begin
    if (!reset && v0 != 8'h0 && !iw0) begin
      chk("d0 sb entry", 72'(q0.size() != 0), 72'd1);
      if (q0.size() != 0) chk("d0 beat", {v0, d0}, q0.pop_front());
    end
    if (!reset && v1 != 8'h0 && !iw1) begin
      chk("d1 sb entry", 72'(q1.size() != 0), 72'd1);
      if (q1.size() != 0) chk("d1 beat", {v1, d1}, q1.pop_front());
    end
    if (!reset && v2 != 8'h0 && !iw2) begin
      chk("d2 sb entry", 72'(q2.size() != 0), 72'd1);
      if (q2.size() != 0) chk("d2 beat", {v2, 48'h0, d2}, q2.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [103:0] pa;
    logic [103:0] pb[3];

    #12;
    chk("rst v0", 72'(v0), 72'd0);
    chk("rst d0", 72'(d0), 72'd0);
    chk("rst wt0", 72'(wt0), 72'd0);
    chk("rst v1", 72'(v1), 72'd0);
    chk("rst wt1", 72'(wt1), 72'd0);
    chk("rst v2", 72'(v2), 72'd0);
    chk("rst d2", 72'(d2), 72'd0);
    @(negedge io_clk); reset = 1'b0;
    @(posedge io_clk); #1;

    // Single packet, two beats
    pa = {40'h12_3456_789A, 64'hFEDC_BA98_7654_ABCD};
    offer0(pa);
    chk("t1 beat0 valid", 72'(v0), 72'hFF);
    chk("t1 beat0 data", 72'(d0), 72'(pa[63:0]));
    @(posedge io_clk); #1;
    chk("t1 beat1 valid", 72'(v0), 72'h1F);
    chk("t1 beat1 data", 72'(d0), 72'({24'h0, pa[103:64]}));
    @(posedge io_clk); #1;
    chk("t1 idle valid", 72'(v0), 72'd0);

`ifndef MTX_PACK_SKIDBUF_EN
    // Three back-to-back packets with access_in held high
    for (int k = 0; k < 3; k++) pb[k] = rnd104();
    acc0 = 1'b1;
    pk0  = pb[0];
    @(negedge io_clk);
    chk("b2b first wait", 72'(wt0), 72'd0);
    push0(pb[0]);
    @(posedge io_clk); #1;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 1) begin
        if (i < 5) pk0 = pb[(i + 1) / 2];
        else       acc0 = 1'b0;
      end
      @(negedge io_clk);
      chk("b2b valid", 72'(v0), (i % 2 == 0) ? 72'hFF : 72'h1F);
      chk("b2b wait_out", 72'(wt0), (i % 2 == 0) ? 72'd1 : 72'd0);
      if (i % 2 == 1 && i < 5) push0(pb[(i + 1) / 2]);
      @(posedge io_clk); #1;
    end
    chk("b2b drain", 72'(v0), 72'd0);
`endif

    // io_wait stall on beat 0
    pa = rnd104();
    offer0(pa);
    iw0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge io_clk);
      chk("stall valid", 72'(v0), 72'hFF);
      chk("stall data", 72'(d0), 72'(pa[63:0]));
      @(posedge io_clk); #1;
    end
    iw0 = 1'b0;
    @(posedge io_clk); #1;
    chk("stall beat1 valid", 72'(v0), 72'h1F);
    chk("stall beat1 data", 72'(d0), 72'({24'h0, pa[103:64]}));
    @(posedge io_clk); #1;
    chk("stall idle", 72'(v0), 72'd0);
    chk("stall sb empty", 72'(q0.size()), 72'd0);

    // PW == IOW: one packet per cycle
    for (int i = 0; i < 4; i++) begin
      pk1  = 64'({$urandom(), $urandom()});
      acc1 = 1'b1;
      @(negedge io_clk);
      chk("d1 wait_out", 72'(wt1), 72'd0);
      if (i > 0) chk("d1 valid", 72'(v1), 72'hFF);
      push1(pk1);
      @(posedge io_clk); #1;
    end
    acc1 = 1'b0;
    chk("d1 last valid", 72'(v1), 72'hFF);
    @(posedge io_clk); #1;
    chk("d1 idle", 72'(v1), 72'd0);

    // PW=40, IOW=16: partial last beat
    pk2  = 40'hA5_5A3C_C3F0;
    acc2 = 1'b1;
    @(negedge io_clk);
    chk("d2 wait_out", 72'(wt2), 72'd0);
    push2(pk2);
    @(posedge io_clk); #1;
    acc2 = 1'b0;
    chk("d2 mask0", 72'(v2), 72'h03);
    @(posedge io_clk); #1;
    chk("d2 mask1", 72'(v2), 72'h03);
    @(posedge io_clk); #1;
    chk("d2 mask2", 72'(v2), 72'h01);
    chk("d2 beat2 data", 72'(d2), 72'h00A5);
    @(posedge io_clk); #1;
    chk("d2 idle", 72'(v2), 72'd0);

    // Reset during beat 1 of 2
    pa = rnd104();
    offer0(pa);
    @(posedge io_clk); #1;
    chk("rmid beat1", 72'(v0), 72'h1F);
    reset = 1'b1;
    q0.delete();
    #1;
    chk("rmid v0", 72'(v0), 72'd0);
    chk("rmid d0", 72'(d0), 72'd0);
    chk("rmid wt0", 72'(wt0), 72'd0);
    @(negedge io_clk); reset = 1'b0;
    @(posedge io_clk); #1;
    chk("rmid idle", 72'(v0), 72'd0);
    pa = rnd104();
    offer0(pa);
    chk("rmid new beat0", 72'(d0), 72'(pa[63:0]));
    repeat (2) @(posedge io_clk);
    #1;

`ifdef MTX_PACK_SKIDBUF_EN
    // Second packet parks in the skid buffer while io_wait holds
    iw0   = 1'b1;
    pa    = rnd104();
    pb[0] = rnd104();
    offer0(pa);
    acc0 = 1'b1;
    pk0  = pb[0];
    @(negedge io_clk);
    chk("skid accept 2nd", 72'(wt0), 72'd0);
    push0(pb[0]);
    @(posedge io_clk); #1;
    acc0 = 1'b0;
    chk("skid wait_out up", 72'(wt0), 72'd1);
    chk("skid hold valid", 72'(v0), 72'hFF);
    chk("skid hold data", 72'(d0), 72'(pa[63:0]));
    @(posedge io_clk); #1;
    chk("skid wait_out held", 72'(wt0), 72'd1);
    iw0 = 1'b0;
    repeat (5) @(posedge io_clk);
    #1;
    chk("skid drained", 72'(v0), 72'd0);
    chk("skid wait_out low", 72'(wt0), 72'd0);
`endif

    chk("final q0 empty", 72'(q0.size()), 72'd0);
    chk("final q1 empty", 72'(q1.size()), 72'd0);
    chk("final q2 empty", 72'(q2.size()), 72'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
